shot_responder: RTL and testbench
=================================

// Module: shot_responder
// PURPOSE
//  Defending side of the battleship shot/answer exchange. Stores our ship map, built from placements
//  made in the PICK_SHIP phase. Accepts a shot coordinate {row,col} from the opponent link and looks it
//  up. Returns a hit/miss answer, tracks remaining ship cells and flags defeat. Sits between the
//  link/receiver and the game-control FSM; its answer feeds the opponent's turn logic.
// PARAMETERS
//  GRID_SIZE   10  board edge in cells (rows and cols); must be <= 16
//  MAX_CELLS   20  max ship cells accepted during placement (saturation limit)
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous active-low reset
//  clear        in   1  synchronous new-game clear; wipes maps and counters, returns to SETUP
//  place_en     in   1  one-cycle pulse: mark place_pos as a ship cell (SETUP only)
//  place_pos    in   8  placement coordinate, [7:4]=row, [3:0]=col
//  arm          in   1  pulse: lock the board and start answering shots
//  shot_valid   in   1  opponent shot present
//  shot_pos     in   8  shot coordinate, [7:4]=row, [3:0]=col
//  shot_ready   out  1  responder can accept a shot
//  ans_valid    out  1  answer available
//  ans_hit      out  1  1 = shot struck an unhit ship cell
//  ans_repeat   out  1  1 = cell was already shot (always reported as miss)
//  ans_ready    in   1  consumer takes the answer
//  cells_placed out  7  ship cells placed so far
//  cells_left   out  7  ship cells not yet hit
//  defeat       out  1  all ship cells sunk
//  state_led    out  4  one-hot state indication for the board LEDs
// BEHAVIOUR
//  Reset (rst_n=0, async): state=SETUP; both maps cleared. All outputs 0, except state_led=4'b1000.
//  Coordinate valid iff row<GRID_SIZE && col<GRID_SIZE; index = row*GRID_SIZE+col. Two bit maps of
//   GRID_SIZE^2 bits: ship_map and shot_map.
//  clear has priority over every other input in every state. On clear: both maps=0, counters=0,
//   state->SETUP, ans_valid->0 on the next edge.
//  FSM:
//   SETUP  : place_en with a valid coord sets ship_map[idx].
//            cells_placed++ only if the bit was 0 and cells_placed<MAX_CELLS.
//            If the bit was already 1, or the coord is invalid or the limit is reached: ignored.
//            arm && cells_placed>0 -> cells_left<=cells_placed, go READY. arm with 0 cells: ignored.
//            shot_ready=0. state_led=1000.
//   READY  : shot_ready=1. shot_valid&&shot_ready on edge N latches shot_pos, go LOOKUP.
//            place_en ignored. state_led=0100.
//   LOOKUP : single cycle. For a valid coord: rep=shot_map[idx]; hit=ship_map[idx]&~rep;
//            shot_map[idx]<=1; cells_left decrements if hit.
//            For an invalid coord: hit=0, rep=0, maps unchanged. Register ans_hit/ans_repeat. Go ANSWER.
//   ANSWER : ans_valid=1 from edge N+2. ans_hit/ans_repeat are stable while ans_valid && !ans_ready.
//            On ans_valid&&ans_ready: ans_valid->0; go DEFEAT if cells_left==0, else READY.
//            shot_ready=0. state_led=0010.
//   DEFEAT : defeat=1, held until clear. shot_ready=0; all shots and placements ignored. state_led=0001.
//  Latency: shot accepted on edge N -> ans_valid high after edge N+2. The next shot can be accepted
//   at the earliest on the edge after the answer handshake.
//  cells_left never underflows: it cannot be decremented at 0, because a hit requires an unhit ship bit.
//  Reset mid-operation (any state): immediate return to reset values; no partial map updates persist.
//  ans_ready while ans_valid=0: no effect.
// TESTING
//  1 Reset, place (1,2),(1,3),(1,3),(A,0); arm -> cells_placed=2 (dup + invalid ignored), cells_left=2, READY.
//  2 Shot (1,2) -> ans_valid exactly 2 cycles after accept, ans_hit=1, ans_repeat=0, cells_left=1.
//  3 Shot (1,2) again -> ans_hit=0, ans_repeat=1, cells_left=1. Shot (5,5) -> miss, repeat=0.
//  4 Hold ans_ready=0 for 10 cycles -> ans_valid/ans_hit stable, shot_ready=0, extra shot_valid not taken.
//  5 Shot (1,3) + ans_ready -> cells_left=0, defeat=1, shot_ready=0. Then clear -> SETUP, all counters 0.
//  6 Place 25 distinct cells with MAX_CELLS=20 -> cells_placed=20. rst_n low during ANSWER -> ans_valid=0 at once.

Source files
------------

// File: rtl/shot_responder.sv
// rtl/shot_responder.sv - battleship defender: ship map, shot lookup, hit/miss answer, defeat tracking
module shot_responder #(
    parameter int GRID_SIZE = 10,
    parameter int MAX_CELLS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       place_en,
    input  logic [7:0] place_pos,
    input  logic       arm,
    input  logic       shot_valid,
    input  logic [7:0] shot_pos,
    output logic       shot_ready,
    output logic       ans_valid,
    output logic       ans_hit,
    output logic       ans_repeat,
    input  logic       ans_ready,
    output logic [6:0] cells_placed,
    output logic [6:0] cells_left,
    output logic       defeat,
    output logic [3:0] state_led
);

    localparam int NCELLS = GRID_SIZE * GRID_SIZE;
    localparam int IDX_W = (NCELLS > 1) ? $clog2(NCELLS) : 1;
    localparam logic [7:0] GS8 = 8'(GRID_SIZE);
    localparam logic [6:0] MAX7 = 7'(MAX_CELLS);

    typedef enum logic [2:0] {
        S_SETUP,
        S_READY,
        S_LOOKUP,
        S_ANSWER,
        S_DEFEAT
    } state_t;

    state_t state, state_nx;

    logic [NCELLS-1:0] ship_map;
    logic [NCELLS-1:0] shot_map;
    logic [7:0]        shot_q;
    logic [IDX_W-1:0]  place_idx;
    logic [IDX_W-1:0]  shot_idx;
    logic              place_ok;
    logic              shot_ok;
    logic              shot_rep;
    logic              shot_hit;

    function automatic logic coord_ok(input logic [7:0] pos);
        return ({4'd0, pos[7:4]} < GS8) && ({4'd0, pos[3:0]} < GS8);
    endfunction

    function automatic logic [IDX_W-1:0] coord_idx(input logic [7:0] pos);
        logic [7:0] full;
        full = {4'd0, pos[7:4]} * GS8 + {4'd0, pos[3:0]};
        return full[IDX_W-1:0];
    endfunction

    // Map reads are only trusted when the coordinate is on the board.
    assign place_idx = coord_idx(place_pos);
    assign shot_idx  = coord_idx(shot_q);
    assign place_ok  = place_en && coord_ok(place_pos) && !ship_map[place_idx]
                       && (cells_placed < MAX7);
    assign shot_ok   = coord_ok(shot_q);
    assign shot_rep  = shot_ok && shot_map[shot_idx];
    assign shot_hit  = shot_ok && ship_map[shot_idx] && !shot_map[shot_idx];
    assign defeat    = (state == S_DEFEAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_SETUP;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        shot_ready = 1'b0;
        state_led  = 4'b0000;
        case (state)
            S_SETUP: begin
                state_led = 4'b1000;
                if (arm && cells_placed != 7'd0) state_nx = S_READY;
            end
            S_READY: begin
                state_led  = 4'b0100;
                shot_ready = 1'b1;
                if (shot_valid) state_nx = S_LOOKUP;
            end
            S_LOOKUP: begin
                state_led = 4'b0010;
                state_nx  = S_ANSWER;
            end
            S_ANSWER: begin
                state_led = 4'b0010;
                if (ans_valid && ans_ready)
                    state_nx = (cells_left == 7'd0) ? S_DEFEAT : S_READY;
            end
            S_DEFEAT: begin
                state_led = 4'b0001;
            end
            default: state_nx = S_SETUP;
        endcase
        if (clear) state_nx = S_SETUP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ship_map     <= '0;
            shot_map     <= '0;
            shot_q       <= 8'd0;
            cells_placed <= 7'd0;
            cells_left   <= 7'd0;
            ans_valid    <= 1'b0;
            ans_hit      <= 1'b0;
            ans_repeat   <= 1'b0;
        end else if (clear) begin
            ship_map     <= '0;
            shot_map     <= '0;
            shot_q       <= 8'd0;
            cells_placed <= 7'd0;
            cells_left   <= 7'd0;
            ans_valid    <= 1'b0;
            ans_hit      <= 1'b0;
            ans_repeat   <= 1'b0;
        end else begin
            case (state)
                S_SETUP: begin
                    if (place_ok) begin
                        ship_map[place_idx] <= 1'b1;
                        cells_placed        <= cells_placed + 7'd1;
                    end
                    if (arm && cells_placed != 7'd0) cells_left <= cells_placed;
                end
                S_READY: begin
                    if (shot_valid) shot_q <= shot_pos;
                end
                S_LOOKUP: begin
                    ans_hit    <= shot_hit;
                    ans_repeat <= shot_rep;
                    if (shot_ok) shot_map[shot_idx] <= 1'b1;
                    if (shot_hit) cells_left <= cells_left - 7'd1;
                end
                S_ANSWER: begin
                    // First ANSWER edge raises valid; handshake edge drops it and leaves.
                    if (!ans_valid) ans_valid <= 1'b1;
                    else if (ans_ready) ans_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shot_responder.sv
// tb/tb_shot_responder.sv - directed vector bench for shot_responder
module tb_shot_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       place_en = 1'b0;
    logic [7:0] place_pos = 8'd0;
    logic       arm = 1'b0;
    logic       shot_valid = 1'b0;
    logic [7:0] shot_pos = 8'd0;
    logic       shot_ready;
    logic       ans_valid;
    logic       ans_hit;
    logic       ans_repeat;
    logic       ans_ready = 1'b0;
    logic [6:0] cells_placed;
    logic [6:0] cells_left;
    logic       defeat;
    logic [3:0] state_led;

    int nvec = 0;
    int nfail = 0;

    shot_responder #(.GRID_SIZE(10), .MAX_CELLS(20)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .place_en     (place_en),
        .place_pos    (place_pos),
        .arm          (arm),
        .shot_valid   (shot_valid),
        .shot_pos     (shot_pos),
        .shot_ready   (shot_ready),
        .ans_valid    (ans_valid),
        .ans_hit      (ans_hit),
        .ans_repeat   (ans_repeat),
        .ans_ready    (ans_ready),
        .cells_placed (cells_placed),
        .cells_left   (cells_left),
        .defeat       (defeat),
        .state_led    (state_led)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       clr;
        logic       pe;
        logic [7:0] pp;
        logic       arm;
        logic       sv;
        logic [7:0] sp;
        logic       ar;
        logic [22:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Expected output word: {shot_ready, ans_valid, ans_hit, ans_repeat, placed, left, defeat, led}
    function automatic logic [22:0] e(input logic sr, input logic av, input logic hit,
                                      input logic rep, input logic [6:0] placed,
                                      input logic [6:0] left, input logic dft,
                                      input logic [3:0] led);
        return {sr, av, hit, rep, placed, left, dft, led};
    endfunction

    function automatic vec_t mk(input string nm, input logic clr, input logic pe,
                                input logic [7:0] pp, input logic am, input logic sv,
                                input logic [7:0] sp, input logic ar, input logic [22:0] ex);
        vec_t v;
        v.name = nm; v.clr = clr; v.pe = pe; v.pp = pp; v.arm = am;
        v.sv = sv; v.sp = sp; v.ar = ar; v.exp = ex;
        return v;
    endfunction

    function automatic logic [22:0] outs();
        return {shot_ready, ans_valid, ans_hit, ans_repeat, cells_placed, cells_left,
                defeat, state_led};
    endfunction

    task automatic check(input string nm, input logic [22:0] ex);
        logic [22:0] act;
        act = outs();
        nvec++;
        if (act !== ex) begin
            nfail++;
            $display("FAIL %s: got sr/av/hit/rep/placed/left/def/led=%b/%b/%b/%b/%0d/%0d/%b/%b want %b/%b/%b/%b/%0d/%0d/%b/%b",
                     nm, act[22], act[21], act[20], act[19], act[18:12], act[11:5], act[4], act[3:0],
                     ex[22], ex[21], ex[20], ex[19], ex[18:12], ex[11:5], ex[4], ex[3:0]);
        end
    endtask

    task automatic idle_inputs();
        clear = 0; place_en = 0; place_pos = 0; arm = 0;
        shot_valid = 0; shot_pos = 0; ans_ready = 0;
    endtask

    task automatic fire_and_wait(input logic [7:0] pos, input string nm);
        bit got;
        got = 0;
        @(negedge clk);
        shot_valid = 1; shot_pos = pos;
        @(posedge clk);
        @(negedge clk);
        shot_valid = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            if (ans_valid) got = 1;
            else @(negedge clk);
        end
        if (!got) begin
            nvec++;
            nfail++;
            $display("FAIL %s: ans_valid timeout got 0 want 1", nm);
        end
    endtask

    initial begin
        // Scenario 1-5 as one cycle-per-record table.
        vecs.push_back(mk("idle_setup",  0,0,8'h00,0,0,8'h00,0, e(0,0,0,0,0,0,0,4'b1000)));
        vecs.push_back(mk("place_12",    0,1,8'h12,0,0,8'h00,0, e(0,0,0,0,1,0,0,4'b1000)));
        vecs.push_back(mk("place_13",    0,1,8'h13,0,0,8'h00,0, e(0,0,0,0,2,0,0,4'b1000)));
        vecs.push_back(mk("place_dup",   0,1,8'h13,0,0,8'h00,0, e(0,0,0,0,2,0,0,4'b1000)));
        vecs.push_back(mk("place_inval", 0,1,8'hA0,0,0,8'h00,0, e(0,0,0,0,2,0,0,4'b1000)));
        vecs.push_back(mk("arm",         0,0,8'h00,1,0,8'h00,0, e(1,0,0,0,2,2,0,4'b0100)));
        vecs.push_back(mk("shot12_acc",  0,0,8'h00,0,1,8'h12,0, e(0,0,0,0,2,2,0,4'b0010)));
        vecs.push_back(mk("shot12_look", 0,0,8'h00,0,0,8'h00,0, e(0,0,1,0,2,1,0,4'b0010)));
        vecs.push_back(mk("shot12_ans",  0,0,8'h00,0,0,8'h00,0, e(0,1,1,0,2,1,0,4'b0010)));
        vecs.push_back(mk("shot12_hs",   0,0,8'h00,0,0,8'h00,1, e(1,0,1,0,2,1,0,4'b0100)));
        vecs.push_back(mk("rep12_acc",   0,0,8'h00,0,1,8'h12,0, e(0,0,1,0,2,1,0,4'b0010)));
        vecs.push_back(mk("rep12_look",  0,0,8'h00,0,0,8'h00,0, e(0,0,0,1,2,1,0,4'b0010)));
        vecs.push_back(mk("rep12_ans",   0,0,8'h00,0,0,8'h00,0, e(0,1,0,1,2,1,0,4'b0010)));
        vecs.push_back(mk("rep12_hs",    0,0,8'h00,0,0,8'h00,1, e(1,0,0,1,2,1,0,4'b0100)));
        vecs.push_back(mk("miss55_acc",  0,0,8'h00,0,1,8'h55,0, e(0,0,0,1,2,1,0,4'b0010)));
        vecs.push_back(mk("miss55_look", 0,0,8'h00,0,0,8'h00,0, e(0,0,0,0,2,1,0,4'b0010)));
        vecs.push_back(mk("miss55_ans",  0,0,8'h00,0,0,8'h00,0, e(0,1,0,0,2,1,0,4'b0010)));
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk("hold_stall", 0,0,8'h00,0,1,8'h13,0, e(0,1,0,0,2,1,0,4'b0010)));
        vecs.push_back(mk("miss55_hs",   0,0,8'h00,0,0,8'h00,1, e(1,0,0,0,2,1,0,4'b0100)));
        vecs.push_back(mk("shot13_acc",  0,0,8'h00,0,1,8'h13,0, e(0,0,0,0,2,1,0,4'b0010)));
        vecs.push_back(mk("shot13_look", 0,0,8'h00,0,0,8'h00,0, e(0,0,1,0,2,0,0,4'b0010)));
        vecs.push_back(mk("shot13_ans",  0,0,8'h00,0,0,8'h00,0, e(0,1,1,0,2,0,0,4'b0010)));
        vecs.push_back(mk("defeat",      0,0,8'h00,0,0,8'h00,1, e(0,0,1,0,2,0,1,4'b0001)));
        vecs.push_back(mk("defeat_hold", 0,1,8'h55,0,1,8'h12,1, e(0,0,1,0,2,0,1,4'b0001)));
        vecs.push_back(mk("clear",       1,0,8'h00,0,0,8'h00,0, e(0,0,0,0,0,0,0,4'b1000)));
        vecs.push_back(mk("clear_prio",  1,1,8'h00,1,0,8'h00,0, e(0,0,0,0,0,0,0,4'b1000)));
        vecs.push_back(mk("arm_empty",   0,0,8'h00,1,0,8'h00,0, e(0,0,0,0,0,0,0,4'b1000)));

        idle_inputs();
        #3;
        check("reset_async", e(0,0,0,0,0,0,0,4'b1000));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;

        foreach (vecs[i]) begin
            @(negedge clk);
            clear = vecs[i].clr; place_en = vecs[i].pe; place_pos = vecs[i].pp;
            arm = vecs[i].arm; shot_valid = vecs[i].sv; shot_pos = vecs[i].sp;
            ans_ready = vecs[i].ar;
            @(posedge clk);
            #1;
            check(vecs[i].name, vecs[i].exp);
        end
        @(negedge clk);
        idle_inputs();

        // Placement saturation: 25 distinct cells offered, only 20 counted.
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            place_en = 1;
            place_pos = {4'(i / 10), 4'(i % 10)};
        end
        @(negedge clk);
        place_en = 0;
        check("place_sat", e(0,0,0,0,20,0,0,4'b1000));
        arm = 1;
        @(negedge clk);
        arm = 0;
        check("arm_sat", e(1,0,0,0,20,20,0,4'b0100));

        fire_and_wait(8'hAB, "shot_inval");
        check("shot_inval", e(0,1,0,0,20,20,0,4'b0010));
        ans_ready = 1;
        @(negedge clk);
        ans_ready = 0;
        check("inval_hs", e(1,0,0,0,20,20,0,4'b0100));

        fire_and_wait(8'h00, "shot00");
        check("shot00", e(0,1,1,0,20,19,0,4'b0010));
        // Async reset in the middle of ANSWER takes effect without a clock edge.
        #2;
        rst_n = 0;
        #1;
        check("reset_in_answer", e(0,0,0,0,0,0,0,4'b1000));
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("after_reset", e(0,0,0,0,0,0,0,4'b1000));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
